// File: rtl/uoram_multichan_walker.sv
// uoram_multichan_walker: round-robin multi-channel front end for the unified ORAM.
// It walks the PosMap chain through the PLB and sequences the backend commands for one request at a time.
module uoram_multichan_walker #(
    parameter int NumChannels    = 4,
    parameter int ChIDWidth      = 2,
    parameter int ORAMU          = 32,
    parameter int BECMDWidth     = 2,
    parameter int Recursion      = 3,
    parameter int DepthWidth     = 2,
    parameter int NumValidBlock  = 1024,
    parameter int LogLeafInBlock = 4
) (
    input  logic                              Clock,
    input  logic                              Reset,
    input  logic [NumChannels-1:0]            CmdInValid,
    output logic [NumChannels-1:0]            CmdInReady,
    input  logic [NumChannels*BECMDWidth-1:0] CmdIn,
    input  logic [NumChannels*ORAMU-1:0]      AddrIn,
    output logic                              LookupValid,
    input  logic                              LookupReady,
    output logic [1:0]                        LookupCmd,
    output logic [ORAMU-1:0]                  LookupAddr,
    input  logic                              ResValid,
    output logic                              ResReady,
    input  logic                              ResHit,
    input  logic                              ResUnInit,
    input  logic                              ResEvict,
    input  logic [ORAMU-1:0]                  ResEvictAddr,
    output logic                              CmdOutValid,
    input  logic                              CmdOutReady,
    output logic [BECMDWidth-1:0]             CmdOut,
    output logic [ORAMU-1:0]                  AddrOut,
    output logic [ChIDWidth-1:0]              ChanOut,
    input  logic                              RefillDone,
    output logic                              Busy,
    output logic                              Error
);
    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] PLOOK  = 4'd1;
    localparam logic [3:0] PWAIT  = 4'd2;
    localparam logic [3:0] ALOOK  = 4'd3;
    localparam logic [3:0] AWAIT  = 4'd4;
    localparam logic [3:0] EVICT  = 4'd5;
    localparam logic [3:0] ISSUE  = 4'd6;
    localparam logic [3:0] RWAIT  = 4'd7;
    localparam logic [3:0] REFILL = 4'd8;
    localparam logic [3:0] INIT   = 4'd9;
    localparam logic [DepthWidth-1:0] MaxDepth = DepthWidth'(Recursion - 1);
    localparam logic [ChIDWidth-1:0]  LastChan = ChIDWidth'(NumChannels - 1);
    localparam logic [BECMDWidth-1:0] Append   = '1;
    localparam logic [BECMDWidth-1:0] ReadRmv  = BECMDWidth'(2);

    logic [3:0]            state;
    logic [ChIDWidth-1:0]  rrPtr, grant, chanQ;
    logic                  grantValid;
    logic [BECMDWidth-1:0] cmdQ;
    logic [DepthWidth-1:0] qDepth;
    logic [ORAMU-1:0]      addrQ [Recursion];
    logic [ORAMU-1:0]      evictAddr, parentAddr;
    logic                  unInitQ, refillPend, silentInit;

    // Round-robin pick: scan downward so the channel closest to rrPtr is written last and wins.
    always_comb begin
        grantValid = 1'b0;
        grant = '0;
        for (int k = NumChannels - 1; k >= 0; k--)
            if (CmdInValid[(int'(rrPtr) + k) % NumChannels]) begin
                grantValid = 1'b1;
                grant = ChIDWidth'((int'(rrPtr) + k) % NumChannels);
            end
    end

    assign parentAddr  = ORAMU'(NumValidBlock) + (addrQ[qDepth] >> LogLeafInBlock);
    assign silentInit  = unInitQ && qDepth != '0;
    assign CmdInReady  = (state == IDLE && grantValid) ? NumChannels'(1) << grant : '0;
    assign LookupValid = state == PLOOK || state == ALOOK || state == REFILL || state == INIT;
    assign LookupCmd   = state == ALOOK ? 2'b01 : state == REFILL ? 2'b10 : state == INIT ? 2'b11 : 2'b00;
    assign LookupAddr  = addrQ[qDepth];
    assign ResReady    = state == PWAIT || state == AWAIT;
    assign CmdOutValid = state == EVICT || (state == ISSUE && !silentInit);
    assign CmdOut      = state == EVICT || unInitQ ? Append : qDepth != '0 ? ReadRmv : cmdQ;
    assign AddrOut     = state == EVICT ? evictAddr : addrQ[qDepth];
    assign ChanOut     = chanQ;
    assign Busy        = state != IDLE;

    // Request walk: accept, descend the PosMap on misses, then climb back issuing backend commands.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            rrPtr <= '0;
            chanQ <= '0;
            cmdQ <= '0;
            qDepth <= '0;
            evictAddr <= '0;
            unInitQ <= 1'b0;
            refillPend <= 1'b0;
            Error <= 1'b0;
            for (int i = 0; i < Recursion; i++) addrQ[i] <= '0;
        end else begin
            if (RefillDone) refillPend <= 1'b1;
            case (state)
                IDLE: if (grantValid) begin
                    addrQ[0] <= AddrIn[int'(grant)*ORAMU +: ORAMU];
                    cmdQ <= CmdIn[int'(grant)*BECMDWidth +: BECMDWidth];
                    chanQ <= grant;
                    qDepth <= '0;
                    rrPtr <= grant == LastChan ? '0 : grant + 1'b1;
                    state <= PLOOK;
                end
                PLOOK: if (LookupReady) state <= PWAIT;
                PWAIT: if (ResValid) begin
                    if (ResHit) state <= ALOOK;
                    else if (qDepth == MaxDepth) begin
                        Error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        addrQ[qDepth + 1'b1] <= parentAddr;
                        qDepth <= qDepth + 1'b1;
                        state <= PLOOK;
                    end
                end
                ALOOK: if (LookupReady) state <= AWAIT;
                AWAIT: if (ResValid) begin
                    unInitQ <= ResUnInit;
                    evictAddr <= ORAMU'(NumValidBlock) + (ResEvictAddr >> LogLeafInBlock);
                    state <= ResEvict ? EVICT : ISSUE;
                end
                EVICT: if (CmdOutReady) state <= ISSUE;
                ISSUE: if (silentInit) state <= INIT;
                       else if (CmdOutReady) state <= qDepth != '0 ? RWAIT : IDLE;
                RWAIT: if (RefillDone || refillPend) begin
                    refillPend <= 1'b0;
                    state <= REFILL;
                end
                REFILL, INIT: if (LookupReady) begin
                    qDepth <= qDepth - 1'b1;
                    state <= ALOOK;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uoram_multichan_walker.sv
// tb_uoram_multichan_walker: directed vector table plus hand-written multi-level walks.
module tb_uoram_multichan_walker;
    logic        Clock = 1'b0, Reset = 1'b0;
    logic [3:0]  CmdInValid = '0, CmdInReady;
    logic [7:0]  CmdIn = '0;
    logic [127:0] AddrIn = '0;
    logic        LookupValid, LookupReady = 1'b0, ResValid = 1'b0, ResReady;
    logic [1:0]  LookupCmd;
    logic [31:0] LookupAddr, AddrOut, ResEvictAddr = '0;
    logic        ResHit = 1'b0, ResUnInit = 1'b0, ResEvict = 1'b0;
    logic        CmdOutValid, CmdOutReady = 1'b0, RefillDone = 1'b0, Busy, Error;
    logic [1:0]  CmdOut, ChanOut;
    int checks = 0, errors = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [1:0]  cmd;
        logic [31:0] base;
        logic [3:0]  expReady;
        logic [1:0]  expChan;
    } vec_t;
    vec_t vecs [9];

    uoram_multichan_walker dut (
        .Clock(Clock), .Reset(Reset), .CmdInValid(CmdInValid), .CmdInReady(CmdInReady),
        .CmdIn(CmdIn), .AddrIn(AddrIn), .LookupValid(LookupValid), .LookupReady(LookupReady),
        .LookupCmd(LookupCmd), .LookupAddr(LookupAddr), .ResValid(ResValid), .ResReady(ResReady),
        .ResHit(ResHit), .ResUnInit(ResUnInit), .ResEvict(ResEvict), .ResEvictAddr(ResEvictAddr),
        .CmdOutValid(CmdOutValid), .CmdOutReady(CmdOutReady), .CmdOut(CmdOut), .AddrOut(AddrOut),
        .ChanOut(ChanOut), .RefillDone(RefillDone), .Busy(Busy), .Error(Error)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expired(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic setChan(input int ch, input logic [1:0] cmd, input logic [31:0] addr);
        CmdIn[ch*2 +: 2] = cmd;
        AddrIn[ch*32 +: 32] = addr;
    endtask

    task automatic req(input logic [3:0] v, input logic [3:0] expR, input string name);
        @(negedge Clock);
        CmdInValid = v;
        #1 chk({name, ".ready"}, CmdInReady, expR);
        @(negedge Clock);
        CmdInValid = '0;
    endtask

    task automatic look(input logic [1:0] c, input logic [31:0] a, input string name);
        int n = 0;
        while (!LookupValid && n < 100) begin @(negedge Clock); n++; end
        if (!LookupValid) begin expired({name, ".look"}); return; end
        chk({name, ".lcmd"}, LookupCmd, c);
        chk({name, ".laddr"}, LookupAddr, a);
        LookupReady = 1'b1;
        @(negedge Clock);
        LookupReady = 1'b0;
    endtask

    task automatic respond(input logic hit, input logic un, input logic ev, input logic [31:0] ea, input string name);
        int n = 0;
        while (!ResReady && n < 100) begin @(negedge Clock); n++; end
        if (!ResReady) begin expired({name, ".res"}); return; end
        {ResValid, ResHit, ResUnInit, ResEvict, ResEvictAddr} = {1'b1, hit, un, ev, ea};
        @(negedge Clock);
        {ResValid, ResHit, ResUnInit, ResEvict, ResEvictAddr} = '0;
    endtask

    task automatic cmdw(input logic [1:0] c, input logic [31:0] a, input logic [1:0] ch,
                        input int hold, input bit preRefill, input string name);
        int n = 0;
        while (!CmdOutValid && n < 100) begin @(negedge Clock); n++; end
        if (!CmdOutValid) begin expired({name, ".cmd"}); return; end
        chk({name, ".cmd"}, CmdOut, c);
        chk({name, ".addr"}, AddrOut, a);
        chk({name, ".chan"}, ChanOut, ch);
        for (int h = 0; h < hold; h++) begin
            @(negedge Clock);
            chk({name, ".hold"}, {CmdOutValid, CmdOut, AddrOut, ChanOut}, {1'b1, c, a, ch});
        end
        if (preRefill) begin
            RefillDone = 1'b1;
            @(negedge Clock);
            RefillDone = 1'b0;
        end
        CmdOutReady = 1'b1;
        @(negedge Clock);
        CmdOutReady = 1'b0;
    endtask

    task automatic pulseRefill(input string name);
        repeat (3) @(negedge Clock);
        chk({name, ".rwait"}, {Busy, LookupValid, CmdOutValid}, 3'b100);
        RefillDone = 1'b1;
        @(negedge Clock);
        RefillDone = 1'b0;
    endtask

    task automatic hitPath(input logic [31:0] a, input logic [1:0] c, input logic [1:0] ch, input string name);
        look(2'b00, a, name);
        respond(1'b1, 1'b0, 1'b0, '0, name);
        look(2'b01, a, name);
        respond(1'b1, 1'b0, 1'b0, '0, name);
        cmdw(c, a, ch, 0, 1'b0, name);
        chk({name, ".idle"}, Busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'b1111, 2'b00, 32'd200, 4'b0001, 2'd0};
        vecs[1] = '{4'b1111, 2'b01, 32'd300, 4'b0010, 2'd1};
        vecs[2] = '{4'b1111, 2'b10, 32'd400, 4'b0100, 2'd2};
        vecs[3] = '{4'b1111, 2'b00, 32'd500, 4'b1000, 2'd3};
        vecs[4] = '{4'b1111, 2'b01, 32'd600, 4'b0001, 2'd0};
        vecs[5] = '{4'b0100, 2'b01, 32'd98,  4'b0100, 2'd2};
        vecs[6] = '{4'b0011, 2'b10, 32'd700, 4'b0001, 2'd0};
        vecs[7] = '{4'b1001, 2'b00, 32'd800, 4'b1000, 2'd3};
        vecs[8] = '{4'b1000, 2'b10, 32'd900, 4'b1000, 2'd3};

        repeat (2) @(negedge Clock);
        chk("reset.outs", {CmdInReady, LookupValid, ResReady, CmdOutValid, Busy, Error}, '0);
        Reset = 1'b1;
        @(negedge Clock);
        chk("reset.after", {Busy, Error, LookupValid}, '0);

        foreach (vecs[i]) begin
            for (int ch = 0; ch < 4; ch++) setChan(ch, vecs[i].cmd, vecs[i].base + ch);
            req(vecs[i].valid, vecs[i].expReady, $sformatf("vec%0d", i));
            hitPath(vecs[i].base + vecs[i].expChan, vecs[i].cmd, vecs[i].expChan, $sformatf("vec%0d", i));
        end

        setChan(0, 2'b00, 32'd100);
        req(4'b0001, 4'b0001, "walk");
        look(2'b00, 32'd100, "walk.d0");
        respond(1'b0, 1'b0, 1'b0, '0, "walk.d0");
        look(2'b00, 32'd1030, "walk.d1");
        respond(1'b0, 1'b0, 1'b0, '0, "walk.d1");
        look(2'b00, 32'd1088, "walk.d2");
        respond(1'b1, 1'b0, 1'b0, '0, "walk.d2");
        look(2'b01, 32'd1088, "walk.u2");
        respond(1'b1, 1'b0, 1'b0, '0, "walk.u2");
        cmdw(2'b10, 32'd1088, 2'd0, 0, 1'b1, "walk.rr2");
        look(2'b10, 32'd1088, "walk.rf2");
        look(2'b01, 32'd1030, "walk.u1");
        respond(1'b1, 1'b0, 1'b0, '0, "walk.u1");
        cmdw(2'b10, 32'd1030, 2'd0, 0, 1'b0, "walk.rr1");
        pulseRefill("walk.rd1");
        look(2'b10, 32'd1030, "walk.rf1");
        look(2'b01, 32'd100, "walk.u0");
        respond(1'b1, 1'b0, 1'b0, '0, "walk.u0");
        cmdw(2'b00, 32'd100, 2'd0, 0, 1'b0, "walk.data");
        chk("walk.idle", Busy, 1'b0);

        setChan(1, 2'b01, 32'd100);
        req(4'b0010, 4'b0010, "evict");
        look(2'b00, 32'd100, "evict.d0");
        respond(1'b0, 1'b0, 1'b0, '0, "evict.d0");
        look(2'b00, 32'd1030, "evict.d1");
        respond(1'b1, 1'b0, 1'b0, '0, "evict.d1");
        look(2'b01, 32'd1030, "evict.u1");
        respond(1'b1, 1'b0, 1'b1, 32'd48, "evict.u1");
        cmdw(2'b11, 32'd1027, 2'd1, 5, 1'b0, "evict.app");
        cmdw(2'b10, 32'd1030, 2'd1, 0, 1'b0, "evict.rr1");
        pulseRefill("evict.rd1");
        look(2'b10, 32'd1030, "evict.rf1");
        look(2'b01, 32'd100, "evict.u0");
        respond(1'b1, 1'b0, 1'b0, '0, "evict.u0");
        cmdw(2'b01, 32'd100, 2'd1, 0, 1'b0, "evict.data");

        setChan(2, 2'b00, 32'd100);
        req(4'b0100, 4'b0100, "uninit");
        look(2'b00, 32'd100, "uninit.d0");
        respond(1'b0, 1'b0, 1'b0, '0, "uninit.d0");
        look(2'b00, 32'd1030, "uninit.d1");
        respond(1'b1, 1'b0, 1'b0, '0, "uninit.d1");
        look(2'b01, 32'd1030, "uninit.u1");
        respond(1'b1, 1'b1, 1'b0, '0, "uninit.u1");
        chk("uninit.nocmd", CmdOutValid, 1'b0);
        look(2'b11, 32'd1030, "uninit.init");
        look(2'b01, 32'd100, "uninit.u0");
        respond(1'b1, 1'b1, 1'b0, '0, "uninit.u0");
        cmdw(2'b11, 32'd100, 2'd2, 0, 1'b0, "uninit.app");

        chk("err.before", Error, 1'b0);
        setChan(0, 2'b01, 32'd100);
        req(4'b0001, 4'b0001, "err");
        look(2'b00, 32'd100, "err.d0");
        respond(1'b0, 1'b0, 1'b0, '0, "err.d0");
        look(2'b00, 32'd1030, "err.d1");
        respond(1'b0, 1'b0, 1'b0, '0, "err.d1");
        look(2'b00, 32'd1088, "err.d2");
        respond(1'b0, 1'b0, 1'b0, '0, "err.d2");
        chk("err.flag", {Error, Busy}, 2'b10);
        setChan(1, 2'b01, 32'd500);
        req(4'b0010, 4'b0010, "after");
        hitPath(32'd500, 2'b01, 2'd1, "after");
        chk("err.sticky", Error, 1'b1);

        setChan(3, 2'b01, 32'd42);
        req(4'b1000, 4'b1000, "abort");
        look(2'b00, 32'd42, "abort.d0");
        #2 Reset = 1'b0;
        #1 chk("abort.outs", {Busy, LookupValid, ResReady, CmdOutValid, Error, CmdInReady}, '0);
        @(negedge Clock);
        Reset = 1'b1;
        setChan(1, 2'b00, 32'd77);
        setChan(3, 2'b00, 32'd78);
        req(4'b1010, 4'b0010, "post");
        hitPath(32'd77, 2'b00, 2'd1, "post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uoram_multichan_walker.md
Name: uoram_multichan_walker

Overview:
Multi-channel front-end sequencer for the unified ORAM. It arbitrates program requests from NumChannels network ports and walks the recursive PosMap chain through the PLB. It then issues the backend command sequence for the winning request: evictions, PosMap ReadRmv, init-refills and the final data-block access. It is a parametrised successor to the single-channel controller. New behaviour: round-robin channel arbitration, channel tagging of backend commands, and a recursion-overflow error.

Parameters:
NumChannels, 4, number of request ports
ChIDWidth, 2, channel tag width, equal to clog2(NumChannels)
ORAMU, 32, program address width
BECMDWidth, 2, backend command width
Recursion, 3, PosMap levels including the data level; the top level always hits the PLB
DepthWidth, 2, clog2(Recursion)
NumValidBlock, 1024, base address of PosMap blocks
LogLeafInBlock, 4, log2 of leaves per PosMap block

Ports:
Clock  in  1  single clock
Reset  in  1  asynchronous, active-low
CmdInValid  in  NumChannels  per-channel request valid
CmdInReady  out  NumChannels  per-channel accept, one-hot or zero
CmdIn  in  NumChannels*BECMDWidth  per-channel command; 00 write, 01 read, 10 read_remove
AddrIn  in  NumChannels*ORAMU  per-channel program address
LookupValid/LookupReady  out/in  1/1  PLB command handshake
LookupCmd  out  2  00 lookup, 01 update, 10 refill, 11 init-refill
LookupAddr  out  ORAMU  PLB address, equal to AddrQ[QDepth]
ResValid/ResReady  in/out  1/1  PLB result handshake
ResHit, ResUnInit, ResEvict  in  1 each  PLB result flags
ResEvictAddr  in  ORAMU  leaf address of the evicted PLB entry
CmdOutValid/CmdOutReady  out/in  1/1  backend command handshake
CmdOut  out  BECMDWidth  backend command; 11 denotes Append
AddrOut  out  ORAMU  backend block address
ChanOut  out  ChIDWidth  originating channel tag
RefillDone  in  1  pulse from the datapath when PosMap block data has been loaded
Busy  out  1  high in any state other than IDLE
Error  out  1  sticky; cleared only by reset

Behaviour:
- Reset (async assert, sync deassert): state IDLE, RRPtr=0, QDepth=0, Error=0, every valid and ready output 0.
- IDLE: grant = first i with CmdInValid[i], scanning from RRPtr modulo NumChannels. CmdInReady[grant]=1 combinationally; all other bits are 0.
- On accept: AddrQ[0]=AddrIn[grant], latch Cmd and channel, QDepth=0, RRPtr=grant+1 (wraps to 0). Go to PLOOK. The accept cycle is not stalled.
- PLOOK: LookupValid=1, LookupCmd=00. On LookupReady, go to PWAIT.
- PWAIT: ResReady=1. On ResValid:
  - hit → ALOOK.
  - miss with QDepth<Recursion-1 → AddrQ[QDepth+1] = NumValidBlock + (AddrQ[QDepth]>>LogLeafInBlock) (ORAMU bits, truncating), QDepth++, go to PLOOK.
  - miss with QDepth==Recursion-1 → Error=1, go to IDLE; the request is dropped.
- ALOOK: LookupCmd=01 (update, remaps the leaf). On LookupReady, go to AWAIT.
- AWAIT: ResReady=1. On ResValid, latch the flags. If ResEvict, go to EVICT; otherwise go to ISSUE.
- EVICT: CmdOut=Append, AddrOut = NumValidBlock + (ResEvictAddr>>LogLeafInBlock). On CmdOutReady, go to ISSUE.
- ISSUE (flags held):
  - UnInit && QDepth>0 → no backend command; go to INIT.
  - UnInit && QDepth==0 → CmdOut=Append, AddrOut=AddrQ[0].
  - !UnInit && QDepth>0 → CmdOut=10 (ReadRmv), AddrOut=AddrQ[QDepth].
  - !UnInit && QDepth==0 → CmdOut=latched Cmd, AddrOut=AddrQ[0].
- After the ISSUE handshake: QDepth>0 → RWAIT; QDepth==0 → IDLE.
- RWAIT: wait for RefillDone, then go to REFILL.
  - RefillDone arriving in an earlier state is latched, so the pulse is never lost.
- REFILL/INIT: LookupCmd = 10 for REFILL, 11 for INIT, LookupAddr=AddrQ[QDepth]. On LookupReady, QDepth-- and go to ALOOK.
- ChanOut equals the latched channel on every CmdOutValid.
- CmdOut, AddrOut and ChanOut stay stable while CmdOutValid && !CmdOutReady. The same holds for the Lookup outputs.
- Asynchronous reset mid-walk abandons the request with no further outputs.
- Exactly one request is in flight at a time.

Test Plan:
- Channel 2 read addr 100; PLB hits at depth 0, no evict → one backend command: CmdOut=01, AddrOut=100, ChanOut=2.
- Channel 0 write addr 100; misses at 100 and 1030, hits at 1088 → LookupAddr sequence 100, 1030, 1088. Backend sequence: ReadRmv 1088, then after RefillDone ReadRmv 1030, then write 100.
- All four channels valid continuously, RRPtr=0 → grants 0,1,2,3,0 across five requests. CmdInReady is never multi-hot.
- Update result for 1030 with ResEvict=1, ResEvictAddr=48 → Append AddrOut=1027 precedes ReadRmv 1030. Hold CmdOutReady low for 5 cycles; outputs must stay stable.
- ResUnInit at depth 1 → no backend command for that level; LookupCmd=11 on 1030. Then a depth-0 uninit → Append AddrOut=100.
- Miss at depth 2 → Error=1, Busy=0 next cycle. A subsequent request is served normally; Error stays 1 until Reset is driven low.
